// File: rtl/eth_f_status_sync_pkg.sv
// eth_f_status_sync_pkg: shared FSM encoding and counter sizing for the status sync scheduler
package eth_f_status_sync_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, HOLD = 2'd2} state_e;
  function automatic int cnt_w(input int h, input int r);
    int m;
    m = (h > r) ? h : r;
    return (m < 2) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/eth_f_rr_arbiter.sv
// eth_f_rr_arbiter: combinational rotate-priority encoder, first requester after last wins
module eth_f_rr_arbiter #(
  parameter int N = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_vld
);
  int idx;
  // scan from farthest to nearest so the nearest requester after last is assigned last
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    idx = 0;
    for (int j = N; j >= 1; j--) begin
      idx = (int'(last) + j) % N;
      if (req[idx[SEL_W-1:0]]) begin
        grant_idx = idx[SEL_W-1:0];
        grant_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/eth_f_status_sync_sched.sv
// eth_f_status_sync_sched: round-robin loader sharing one multibit status synchronizer
module eth_f_status_sync_sched
  import eth_f_status_sync_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W = $clog2(NUM_SRC),
  parameter int HOLD_CYCLES = 8,
  parameter int REFRESH_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_SRC*WIDTH-1:0] din,
  output logic [WIDTH-1:0]         hold_data,
  output logic [SEL_W-1:0]         hold_sel,
  output logic                     hold_toggle,
  output logic                     busy
);
  localparam int CW = cnt_w(HOLD_CYCLES, REFRESH_CYCLES);
  state_e state, state_nxt;
  logic [WIDTH-1:0] shadow [NUM_SRC];
  logic [WIDTH-1:0] gnt_word;
  logic [NUM_SRC-1:0] pending, change, clr;
  logic [SEL_W-1:0] ptr, gnt;
  logic gnt_vld, load, refresh;
  logic [CW-1:0] hold_cnt, ref_cnt;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_chg
    assign change[i] = din[i*WIDTH +: WIDTH] != shadow[i];
  end

  eth_f_rr_arbiter #(.N(NUM_SRC), .SEL_W(SEL_W)) u_arb (
    .req(pending),
    .last(ptr),
    .grant_idx(gnt),
    .grant_vld(gnt_vld)
  );

  assign gnt_word = din[gnt*WIDTH +: WIDTH];
  assign refresh = (REFRESH_CYCLES != 0) && (ref_cnt == CW'(REFRESH_CYCLES - 1));
  assign clr = (load && gnt_vld) ? NUM_SRC'(1) << gnt : '0;

  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;

  // next state: leave IDLE or finish HOLD only when something is pending
  always_comb
    state_nxt = state == IDLE ? (|pending ? LOAD : IDLE)
              : state == LOAD ? HOLD
              : hold_cnt == '0 ? (|pending ? LOAD : IDLE) : HOLD;

  // state-decoded controls
  always_comb begin
    busy = state != IDLE;
    load = state == LOAD;
  end

  // datapath: capture granted word, track pending changes and counters
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hold_data <= '0;
      hold_sel <= '0;
      hold_toggle <= 1'b0;
      ptr <= SEL_W'(NUM_SRC - 1);
      pending <= '1;
      hold_cnt <= '0;
      ref_cnt <= '0;
      for (int i = 0; i < NUM_SRC; i++) shadow[i] <= '0;
    end else begin
      pending <= (pending | change | {NUM_SRC{refresh}}) & ~clr;
      ref_cnt <= (refresh || REFRESH_CYCLES == 0) ? '0 : ref_cnt + 1'b1;
      if (load && gnt_vld) begin
        hold_data <= gnt_word;
        hold_sel <= gnt;
        hold_toggle <= ~hold_toggle;
        shadow[gnt] <= gnt_word;
        ptr <= gnt;
        hold_cnt <= CW'(HOLD_CYCLES - 1);
      end else if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
    end
endmodule

// File: tb/tb_eth_f_status_sync_sched.sv
// tb_eth_f_status_sync_sched: random and directed stimulus against a load-schedule reference model
module tb_eth_f_status_sync_sched;
  localparam int W = 32, N = 4, SW = 2, H = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;
  logic [N*W-1:0] din;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int R = k ? 64 : 0;
    logic [W-1:0] hd;
    logic [SW-1:0] hs;
    logic ht, bz;
    eth_f_status_sync_sched #(.WIDTH(W), .NUM_SRC(N), .HOLD_CYCLES(H), .REFRESH_CYCLES(R)) u_dut (
      .clk(clk),
      .reset_n(rst_n),
      .din(din),
      .hold_data(hd),
      .hold_sel(hs),
      .hold_toggle(ht),
      .busy(bz)
    );
    // reference: a load happens the cycle after a free decision point with work pending;
    // the next decision point is HOLD cycles after the load
    logic [W-1:0] m_data, m_sh [N];
    logic [SW-1:0] m_sel;
    logic m_tog, m_busy, m_load, nl, rf;
    logic [N-1:0] m_pend, np;
    int m_ptr, m_dec, m_cyc, m_rc, g;
    always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        m_data = '0; m_sel = '0; m_tog = 1'b0; m_busy = 1'b0; m_load = 1'b0;
        m_pend = '1; m_ptr = N - 1; m_dec = -1; m_cyc = 0; m_rc = 0;
        for (int i = 0; i < N; i++) m_sh[i] = '0;
      end else begin
        rf = (R != 0) && (m_rc == R - 1);
        m_rc = rf ? 0 : m_rc + 1;
        nl = !m_load && m_cyc >= m_dec && (m_pend != '0);
        for (int i = 0; i < N; i++) np[i] = m_pend[i] | (din[i*W +: W] != m_sh[i]) | rf;
        if (m_load) begin
          g = -1;
          for (int j = 1; j <= N; j++) if (g < 0 && m_pend[(m_ptr + j) % N]) g = (m_ptr + j) % N;
          if (g >= 0) begin
            m_data = din[g*W +: W];
            m_sel = SW'(g);
            m_tog = ~m_tog;
            m_sh[g] = m_data;
            m_ptr = g;
            np[g] = 1'b0;
            m_dec = m_cyc + H;
          end
        end
        m_pend = np;
        m_load = nl;
        m_busy = nl || (m_cyc + 1 <= m_dec);
        m_cyc++;
      end
    always @(negedge clk)
      if (chk_en) begin
        chk($sformatf("data%0d", k), 64'(hd), 64'(m_data));
        chk($sformatf("sel%0d", k), 64'(hs), 64'(m_sel));
        chk($sformatf("toggle%0d", k), 64'(ht), 64'(m_tog));
        chk($sformatf("busy%0d", k), 64'(bz), 64'(m_busy));
      end
  end

  task automatic set_word(input int i, input logic [W-1:0] v);
    din[i*W +: W] = v;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) set_word(i, 32'h1000 + i);
    @(posedge clk);
    #1 chk_en = 1'b1;
    cyc(1);
    rst_n = 1'b1;
    cyc(45);
    chk("s1_sel", 64'(g_dut[0].hs), 64'd3);
    chk("s1_data", 64'(g_dut[0].hd), 64'h1003);
    chk("s1_toggle", 64'(g_dut[0].ht), 64'd0);
    chk("s1_idle", 64'(g_dut[0].bz), 64'd0);
    set_word(2, 32'hDEAD_BEEF);
    cyc(3);
    chk("s2_sel", 64'(g_dut[0].hs), 64'd2);
    chk("s2_data", 64'(g_dut[0].hd), 64'hDEAD_BEEF);
    chk("s2_toggle", 64'(g_dut[0].ht), 64'd1);
    cyc(12);
    chk("s2_idle", 64'(g_dut[0].bz), 64'd0);
    set_word(1, 32'h1111_0001);
    set_word(3, 32'h3333_0003);
    cyc(3);
    chk("s3_first", 64'(g_dut[0].hs), 64'd3);
    cyc(9);
    chk("s3_second", 64'(g_dut[0].hs), 64'd1);
    chk("s3_data", 64'(g_dut[0].hd), 64'h1111_0001);
    cyc(12);
    set_word(0, 32'hA0A0_0000);
    cyc(2);
    set_word(0, 32'hB0B0_0000);
    cyc(1);
    chk("s4_capture", 64'(g_dut[0].hd), 64'hB0B0_0000);
    cyc(1);
    set_word(0, 32'hC0C0_0000);
    cyc(6);
    chk("s4_hold", 64'(g_dut[0].hd), 64'hB0B0_0000);
    cyc(4);
    chk("s4_resend", 64'(g_dut[0].hd), 64'hC0C0_0000);
    for (int n = 0; n < 400; n++) begin
      rst_n = 1'b1;
      if ($urandom_range(5) == 0) set_word($urandom_range(N - 1), $urandom_range(3) == 0 ? $urandom : 32'($urandom_range(3)));
      if ($urandom_range(149) == 0) rst_n = 1'b0;
      cyc(1);
    end
    rst_n = 1'b1;
    cyc(20);
    set_word(1, 32'h5555_AAAA);
    cyc(6);
    rst_n = 1'b0;
    #1;
    chk("s6_data", 64'(g_dut[0].hd), 64'd0);
    chk("s6_sel", 64'(g_dut[0].hs), 64'd0);
    chk("s6_toggle", 64'(g_dut[0].ht), 64'd0);
    chk("s6_busy", 64'(g_dut[0].bz), 64'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
    chk("s6_first", 64'(g_dut[0].hs), 64'd0);
    chk("s6_first_tog", 64'(g_dut[0].ht), 64'd1);
    cyc(43);
    chk("s6_sel_end", 64'(g_dut[0].hs), 64'd3);
    chk("s6_tog_end", 64'(g_dut[0].ht), 64'd0);
    chk("s6_idle", 64'(g_dut[0].bz), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
